// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the toggle CDC receiver
package cdc_pkg;

    // Receiver handshake states: waiting for a new toggle, or holding a captured word
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cdc_state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SYNC_MIN            = 2;
    localparam int SYNC_MAX            = 4;

endpackage

// File: rtl/sync_nff.sv
// rtl/sync_nff.sv - single-bit N-flop synchronizer
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk2,
    input  logic rst2_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous bit through the flop chain; only the last stage is used
    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_toggle_rx.sv
// rtl/cdc_toggle_rx.sv - destination-side receiver for a two-phase toggle crossing
module cdc_toggle_rx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk2,
    input  logic              rst2_n,
    input  logic              req_tgl_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              ack_tgl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              proto_err
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync_stages
        $error("cdc_toggle_rx: SYNC_STAGES out of legal range");
    end

    cdc_state_t        state;
    cdc_state_t        state_n;
    logic              req_s;
    logic              req_last;
    logic              req_last_n;
    logic              ack_n;
    logic              valid_n;
    logic [DATA_W-1:0] data_n;
    logic              busy_n;
    logic              err_n;
    logic              event_seen;
    logic              handshake;

    // The request toggle is the only control that crosses into clk2
    sync_nff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk2   (clk2),
        .rst2_n (rst2_n),
        .d      (req_tgl_async),
        .q      (req_s)
    );

    assign event_seen = (req_s != req_last);
    assign handshake  = out_valid && out_ready;

    // Next-state and next-output decode; every register holds unless a transition updates it
    always_comb begin
        state_n    = state;
        req_last_n = req_last;
        ack_n      = ack_tgl;
        valid_n    = out_valid;
        data_n     = out_data;
        busy_n     = busy;
        err_n      = proto_err;
        unique case (state)
            IDLE: begin
                if (event_seen) begin
                    // data_async has been stable since before the toggle entered the synchronizer
                    data_n  = data_async;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // In HOLD req_s should sit at the opposite phase of req_last; a return
                // means the source toggled again before seeing the ack
                if (req_s == req_last) begin
                    err_n = 1'b1;
                end
                if (handshake) begin
                    valid_n    = 1'b0;
                    busy_n     = 1'b0;
                    ack_n      = ~ack_tgl;
                    req_last_n = req_s;
                    state_n    = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and all outputs are registered so the ack crossing is driven straight from a flop
    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            state     <= IDLE;
            req_last  <= 1'b0;
            ack_tgl   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            req_last  <= req_last_n;
            ack_tgl   <= ack_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            busy      <= busy_n;
            proto_err <= err_n;
        end
    end

endmodule

// File: tb/tb_cdc_toggle_rx.sv
// tb/tb_cdc_toggle_rx.sv - scoreboard bench for cdc_toggle_rx
module tb_cdc_toggle_rx;

    logic       clk2;
    logic       rst2_n;
    logic       req_tgl_async;
    logic [7:0] data_async;
    logic       ack_tgl;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       proto_err;

    logic       req3;
    logic [7:0] data3;
    logic       ack3;
    logic       valid3;
    logic [7:0] out_data3;
    logic       ready3;
    logic       busy3;
    logic       err3;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic       exp_ack;
    int         lat2;
    int         lat3;

    cdc_toggle_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk2          (clk2),
        .rst2_n        (rst2_n),
        .req_tgl_async (req_tgl_async),
        .data_async    (data_async),
        .ack_tgl       (ack_tgl),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    cdc_toggle_rx #(.DATA_W(8), .SYNC_STAGES(3)) dut3 (
        .clk2          (clk2),
        .rst2_n        (rst2_n),
        .req_tgl_async (req3),
        .data_async    (data3),
        .ack_tgl       (ack3),
        .out_valid     (valid3),
        .out_data      (out_data3),
        .out_ready     (ready3),
        .busy          (busy3),
        .proto_err     (err3)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted word must match the oldest word the source published
    always @(negedge clk2) begin
        if (rst2_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk2);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk2);
        #1;
        data_async    = d;
        req_tgl_async = ~req_tgl_async;
        exp_q.push_back(d);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk2);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (ack_tgl !== exp_ack && n < 30) begin
            @(posedge clk2);
            #1;
            n++;
        end
        check("ack_phase", 32'(ack_tgl), 32'(exp_ack));
    endtask

    initial begin
        int lat;
        checks        = 0;
        errors        = 0;
        exp_ack       = 1'b0;
        rst2_n        = 1'b0;
        req_tgl_async = 1'b0;
        data_async    = 8'h00;
        out_ready     = 1'b0;
        req3          = 1'b0;
        data3         = 8'h00;
        ready3        = 1'b0;
        tick(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ack", 32'(ack_tgl), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst2_n = 1'b1;
        tick(3);

        // single transfer with ready high
        out_ready = 1'b1;
        send(8'hA5);
        wait_valid(lat2);
        check("lat_default", 32'(lat2), 32'd3);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ack_pre", 32'(ack_tgl), 32'd0);
        tick(1);
        exp_ack = ~exp_ack;
        check("t1_valid_pulse", 32'(out_valid), 32'd0);
        check("t1_ack_post", 32'(ack_tgl), 32'd1);
        check("t1_busy_post", 32'(busy), 32'd0);

        // backpressure for 10 cycles
        tick(2);
        out_ready = 1'b0;
        send(8'h3C);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h3C);
            check("bp_ack", 32'(ack_tgl), 32'(exp_ack));
        end
        out_ready = 1'b1;
        tick(1);
        exp_ack = ~exp_ack;
        check("bp_ack_flip", 32'(ack_tgl), 32'(exp_ack));

        // 16 back-to-back transfers, source waits for the ack each time
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            exp_ack = ~exp_ack;
            wait_ack();
        end
        tick(2);
        check("b2b_ack_end", 32'(ack_tgl), 32'd0);
        check("b2b_err", 32'(proto_err), 32'd0);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // double toggle while holding a word
        out_ready = 1'b0;
        send(8'h77);
        wait_valid(lat);
        tick(1);
        req_tgl_async = ~req_tgl_async;
        tick(5);
        req_tgl_async = ~req_tgl_async;
        tick(5);
        check("pe_err", 32'(proto_err), 32'd1);
        check("pe_valid", 32'(out_valid), 32'd1);
        check("pe_data", 32'(out_data), 32'h77);
        out_ready = 1'b1;
        tick(1);
        exp_ack = ~exp_ack;
        check("pe_ack", 32'(ack_tgl), 32'(exp_ack));
        tick(20);
        check("pe_no_extra", 32'(out_valid), 32'd0);
        check("pe_err_sticky", 32'(proto_err), 32'd1);
        check("pe_q_empty", 32'(exp_q.size()), 32'd0);

        // asynchronous reset while in HOLD
        out_ready = 1'b0;
        send(8'h55);
        wait_valid(lat);
        @(posedge clk2);
        #3;
        rst2_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_ack", 32'(ack_tgl), 32'd0);
        check("ar_err", 32'(proto_err), 32'd0);
        exp_q.delete();
        req_tgl_async = 1'b0;
        exp_ack       = 1'b0;
        @(posedge clk2);
        #1;
        rst2_n = 1'b1;
        tick(3);
        out_ready = 1'b1;
        send(8'h81);
        wait_valid(lat);
        check("ar_new_data", 32'(out_data), 32'h81);
        exp_ack = ~exp_ack;
        wait_ack();
        check("ar_q_empty", 32'(exp_q.size()), 32'd0);

        // deeper synchronizer adds exactly one cycle
        ready3 = 1'b1;
        @(posedge clk2);
        #1;
        data3 = 8'h5A;
        req3  = 1'b1;
        lat3  = 0;
        while (lat3 < 20) begin
            @(posedge clk2);
            #1;
            lat3++;
            if (valid3) break;
        end
        check("s3_valid", 32'(valid3), 32'd1);
        check("s3_data", 32'(out_data3), 32'h5A);
        check("s3_lat_delta", 32'(lat3 - lat2), 32'd1);
        tick(1);
        check("s3_ack", 32'(ack3), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_toggle_rx.md
Name: cdc_toggle_rx

Overview:
- Destination-domain receiver for a two-phase (toggle) request/acknowledge crossing.
- A source domain publishes a data word, then flips `req_tgl_async`. This block synchronizes the toggle, captures the held data word and presents it on a valid/ready interface.
- It returns a registered, glitch-free `ack_tgl` toggle to the source.
- All control that crosses domains is a single registered bit. No combinational logic feeds a crossing.

Parameters:
- DATA_W, 8, width of the transferred data word.
- SYNC_STAGES, 2, flop count of the request-toggle synchronizer; legal range 2..4.

Ports:
- clk2  input  1  destination clock; the only clock in the block.
- rst2_n  input  1  reset; asynchronous assert, active-low.
- req_tgl_async  input  1  request toggle from the source domain; asynchronous to clk2.
- data_async  input  DATA_W  source data word; the source holds it stable from before the request toggle until it sees the matching ack toggle.
- ack_tgl  output  1  acknowledge toggle to the source; driven directly from a flop.
- out_valid  output  1  a captured word is available.
- out_data  output  DATA_W  captured word; registered.
- out_ready  input  1  downstream accepts the word when high together with out_valid.
- busy  output  1  high from event detection until the ack toggle; registered.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst2_n low, asynchronous) clears all of the following to 0:
  - sync chain, req_last, ack_tgl, out_valid, out_data, busy, proto_err;
  - state goes to IDLE.
- Reset release is synchronous to clk2. Both sides must be reset together so that toggle phases agree.
- Synchronizer: req_tgl_async passes through SYNC_STAGES flops, producing req_s. Only req_s is used by logic; no other use of req_tgl_async is permitted.
- Event condition: req_s != req_last.
- FSM states: IDLE, HOLD.
  - IDLE with an event:
    - out_data <= data_async, sampled in that cycle; the data has been stable for at least SYNC_STAGES cycles, so the sample is safe.
    - out_valid <= 1, busy <= 1, go to HOLD.
  - IDLE with no event: hold all outputs.
  - HOLD with out_valid && out_ready:
    - out_valid <= 0, busy <= 0;
    - ack_tgl <= ~ack_tgl;
    - req_last <= req_s;
    - go to IDLE.
  - HOLD without out_ready: out_valid and out_data stay stable (standard valid/ready; valid is never withdrawn).
- Latency:
  - Toggle edge on req_tgl_async to out_valid high: SYNC_STAGES+1 clk2 edges, with ±1 cycle of metastability uncertainty.
  - Handshake to ack_tgl flip: 1 cycle.
  - With out_ready held high, back-to-back transfers are gated only by the source round trip.
- Protocol violation:
  - Condition: req_s changes while in HOLD, i.e. the source toggled again before receiving ack.
  - Response: proto_err <= 1 and stays 1 until reset.
  - Data in flight is unaffected. req_last is still updated from req_s at the handshake, so a double toggle collapses to no event, and that word is lost.
- out_ready high in IDLE has no effect.
- An event in the same cycle as the handshake: not possible, since req_last is updated at the handshake. The next event is detected the following cycle at the earliest.
- Reset mid-transfer: the word is dropped, ack_tgl returns to 0 and out_valid drops immediately (asynchronously).

Decomposition:
- Shared package cdc_pkg holds:
  - the FSM state enum (IDLE, HOLD);
  - the constant SYNC_STAGES_DEFAULT = 2;
  - the legal-range bounds SYNC_MIN = 2 and SYNC_MAX = 4, checked by an elaboration assertion.
- One sub-module: sync_nff, a single-bit N-flop synchronizer with the same clk2/rst2_n style and parameter STAGES. It is reused elsewhere for level crossings.

Test Plan:
- Reset, then one toggle of req_tgl_async with data_async=0xA5, out_ready=1:
  - out_valid pulses for 1 cycle SYNC_STAGES+1 (±1) edges after the toggle;
  - out_data=0xA5;
  - ack_tgl goes 0→1 one cycle after the handshake;
  - busy falls with the ack.
- out_ready=0 for 10 cycles after a toggle with data 0x3C:
  - out_valid and out_data=0x3C are held stable for all 10 cycles;
  - ack_tgl does not change until the cycle after out_ready rises.
- 16 back-to-back transfers with incrementing data 0x00..0x0F, where the source waits for ack before each toggle: all 16 words are delivered in order, ack_tgl ends at 0 (16 flips), and proto_err=0.
- Source toggles twice while in HOLD with out_ready=0:
  - proto_err=1 and remains high;
  - the first word is still delivered;
  - no extra out_valid is produced for the collapsed toggle pair.
- Assert rst2_n low while in HOLD, asynchronously mid-cycle:
  - out_valid, busy and ack_tgl go to 0 immediately;
  - after release, a new toggle with data 0x81 is delivered normally.
- SYNC_STAGES=3 build: toggle-to-valid latency increases by exactly 1 cycle compared with the default build.
